// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for seq_bit_serializer.
// master = upstream word source + downstream bit consumer; slave = serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             bit_en;
  logic             x_out;
  logic             x_valid;
  logic             word_start;
  logic             word_done;
  logic             busy;

  modport master (
    output in_valid, in_data, bit_en,
    input  in_ready, x_out, x_valid, word_start, word_done, busy
  );

  modport slave (
    input  in_valid, in_data, bit_en,
    output in_ready, x_out, x_valid, word_start, word_done, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits one bit per enabled clock on x_out. A one-word pending buffer allows
// back-to-back words to stream with no idle bit between them.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  seq_bit_serializer_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0]   pend_reg, pend_next;
  logic               pend_full_reg, pend_full_next;

  logic [WIDTH-1:0]   shifted;
  logic               head_bit;
  logic               accept;
  logic               last_bit;

  // The shifter moves one position toward the output end, filling with 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  assign head_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];

  // in_ready depends only on the pending flag so upstream never sees a
  // combinational path from its own in_valid.
  assign accept   = bus.in_valid & ~pend_full_reg;
  assign last_bit = (bit_cnt_reg == LAST_IDX);

  assign bus.in_ready   = ~pend_full_reg;
  assign bus.x_valid    = (state_reg == SHIFT);
  assign bus.x_out      = (state_reg == SHIFT) ? head_bit : IDLE_BIT;
  assign bus.word_start = (state_reg == SHIFT) && (bit_cnt_reg == '0);
  assign bus.word_done  = (state_reg == SHIFT) && last_bit;
  assign bus.busy       = (state_reg == SHIFT) | pend_full_reg;

  // State and datapath registers; reset discards any word in flight or pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      pend_reg      <= pend_next;
      pend_full_reg <= pend_full_next;
    end
  end

  // Next-state: load, shift, hand over to the pending word, or fall idle.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    pend_next      = pend_reg;
    pend_full_next = pend_full_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next   = bus.in_data;
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.bit_en && last_bit) begin
          // Word boundary: a held word wins; in_ready is low while one is
          // held, so a new accept cannot collide with the drain.
          if (pend_full_reg) begin
            shift_next     = pend_reg;
            bit_cnt_next   = '0;
            pend_full_next = 1'b0;
          end else if (accept) begin
            shift_next   = bus.in_data;
            bit_cnt_next = '0;
          end else begin
            shift_next   = '0;
            bit_cnt_next = '0;
            state_next   = IDLE;
          end
        end else begin
          if (bus.bit_en) begin
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
          if (accept) begin
            pend_next      = bus.in_data;
            pend_full_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: directed scenarios plus random traffic,
// checked every cycle against a bit-queue reference, and an integration run
// of an LSB-first instance feeding a non-overlapping 1010 detector model.
module tb_seq_bit_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) bus  ();
  seq_bit_serializer_if #(.WIDTH(W)) bus2 ();

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  int   total = 0;
  int   bad   = 0;
  bit   q[$];          // every accepted but not yet consumed bit, in emit order
  logic acc_last;
  logic xv_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference view: outputs follow purely from how many bits are queued.
  task automatic chk_outputs();
    int n;
    n = q.size();
    chk("x_out",      bus.x_out,      (n > 0) ? q[0] : 1'b0);
    chk("x_valid",    bus.x_valid,    n > 0);
    chk("word_start", bus.word_start, (n > 0) && (n % W == 0));
    chk("word_done",  bus.word_done,  (n % W) == 1);
    chk("busy",       bus.busy,       n > 0);
    chk("in_ready",   bus.in_ready,   n <= W);
  endtask

  // One clock: drive, check at negedge, update the model at posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic en);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.bit_en   = en;
    @(negedge clk);
    chk_outputs();
    xv_seen = bus.x_valid;
    @(posedge clk);
    acc_last = v && (q.size() <= W);
    if (q.size() > 0 && en) void'(q.pop_front());
    if (acc_last) begin
      for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
      $display("accept word %02h queued_bits=%0d", d, q.size());
    end
    #1;
  endtask

  initial begin
    int xv_cnt;
    int idx;
    int k_at;
    logic [W-1:0] words [3];
    int bitnum, zcount, len;
    int zpos [2];
    logic [3:0] hist;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.bit_en = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.bit_en = 1'b0;
    #1;
    chk_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word, MSB first
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1);

    // Back-to-back, second word offered while bit 2 is out
    step(1'b1, 8'hAA, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 2 * W; i++) step(1'b0, 8'h00, 1'b1);

    // Stall for 3 cycles with bit index 3 on x_out
    xv_cnt = 0;
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin step(1'b0, 8'h00, 1'b1); xv_cnt += int'(xv_seen); end
    for (int i = 0; i < 3; i++) begin step(1'b0, 8'h00, 1'b0); xv_cnt += int'(xv_seen); end
    for (int i = 0; i < 7; i++) begin step(1'b0, 8'h00, 1'b1); xv_cnt += int'(xv_seen); end
    chk("stall_valid_cycles", xv_cnt, 11);

    // Backpressure: three words offered continuously
    words[0] = 8'h3C; words[1] = 8'hF0; words[2] = 8'h96;
    idx = 0; k_at = 0;
    for (int k = 1; k <= 40 && idx < 3; k++) begin
      step(1'b1, words[idx], 1'b1);
      if (acc_last) begin idx++; if (idx == 3) k_at = k; end
    end
    chk("bp_accepted", idx, 3);
    chk("bp_third_accept_step", k_at, 10);
    for (int i = 0; i < 2 * W + 2; i++) step(1'b0, 8'h00, 1'b1);

    // Async reset mid-word with a word pending
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_x_valid",  bus.x_valid,  1'b0);
    chk("rst_x_out",    bus.x_out,    1'b0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < W + 4; i++) step(1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 2 * W + 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", q.size(), 0);

    // Integration: LSB-first 0x55 into a non-overlapping 1010 detector
    bus2.in_valid = 1'b1; bus2.in_data = 8'h55; bus2.bit_en = 1'b1;
    @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    $display("accept word 55 on lsb-first instance");
    bitnum = 0; zcount = 0; len = 0; hist = '0; zpos[0] = 0; zpos[1] = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (bus2.x_valid) begin
        bitnum++;
        hist = {hist[2:0], bus2.x_out};
        len++;
        if (len >= 4 && hist == 4'b1010) begin
          if (zcount < 2) zpos[zcount] = bitnum;
          zcount++;
          len = 0;
        end
      end
    end
    chk("int_bits", bitnum, W);
    chk("int_z_count", zcount, 2);
    chk("int_z_first", zpos[0], 4);
    chk("int_z_second", zpos[1], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
